multiplicador_4x4: RTL and testbench

- Unsigned 4-bit × 4-bit multiplier producing an 8-bit product, exposed as individual bit ports.
- Inputs are scalar bits, MSB first per operand; outputs are scalar bits, MSB first.
- Product is computed by combinational logic (array multiplier: AND partial products plus adder tree) and registered once.
- Used as a leaf arithmetic block in the logic-minimization exercise datapath.

---
 rtl/multiplicador_4x4.sv | 100 ++++++++++
 tb/tb_multiplicador_4x4.sv | 127 ++++++++++++
 2 files changed

// File: rtl/multiplicador_4x4.sv
// Unsigned 4x4 array multiplier with a registered 8-bit product on scalar bit ports.
// Latency: 1 cycle from operand bits to o0..o7, one new product accepted every cycle.
// Backpressure: none; the block always accepts inputs and always presents a product.
//
// Ports:
//   clk            system clock, rising-edge
//   rst            synchronous active-high reset, clears the product register
//   a,b,c,d        operand A bits 3..0 (a is the MSB)
//   e,f,g,h        operand B bits 3..0 (e is the MSB)
//   o0..o7         product bits 7..0 (o0 is the MSB), driven straight from flops
//   par            (only with MULTIPLICADOR_PARITY_EN) XOR of the 8 product bits,
//                  registered in the same stage as o0..o7
module multiplicador_4x4 (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic e,
   input  logic f,
   input  logic g,
   input  logic h,
   output logic o0,
   output logic o1,
   output logic o2,
   output logic o3,
   output logic o4,
   output logic o5,
   output logic o6,
   output logic o7
`ifdef MULTIPLICADOR_PARITY_EN
   ,
   output logic par
`endif
);

   logic [3:0]       op_a;
   logic [3:0]       op_b;
   logic [3:0][3:0]  pp;      // pp[i][j] = A[i] & B[j]
   logic [7:0]       acc;     // running sum of shifted partial-product rows
   logic             carry;
   logic             sum;
   logic [7:0]       prod_q;

   assign op_a = {a, b, c, d};
   assign op_b = {e, f, g, h};

   // Ripple-carry array: row 0 seeds the accumulator, then each row j
   // (weight 2^j) is added with a chain of four full adders. After row j-1
   // the accumulator occupies bits 0..j+3, so the final carry of row j
   // lands in the still-empty bit j+4.
   always_comb begin
      sum   = 1'b0;
      carry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pp[i][j] = op_a[i] & op_b[j];
         end
      end
      acc = {4'b0000, pp[3][0], pp[2][0], pp[1][0], pp[0][0]};
      for (int j = 1; j < 4; j++) begin
         carry = 1'b0;
         for (int k = 0; k < 4; k++) begin
            sum        = acc[j+k] ^ pp[k][j] ^ carry;
            carry      = (acc[j+k] & pp[k][j]) | (carry & (acc[j+k] ^ pp[k][j]));
            acc[j+k]   = sum;
         end
         acc[j+4] = carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= 8'h00;
      end else begin
         prod_q <= acc;
      end
   end

`ifdef MULTIPLICADOR_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par <= 1'b0;
      end else begin
         par <= ^acc;
      end
   end
`endif

   assign o0 = prod_q[7];
   assign o1 = prod_q[6];
   assign o2 = prod_q[5];
   assign o3 = prod_q[4];
   assign o4 = prod_q[3];
   assign o5 = prod_q[2];
   assign o6 = prod_q[1];
   assign o7 = prod_q[0];

endmodule

// File: tb/tb_multiplicador_4x4.sv
module tb_multiplicador_4x4;

   logic clk = 1'b0;
   logic rst;
   logic a, b, c, d, e, f, g, h;
   logic o0, o1, o2, o3, o4, o5, o6, o7;
`ifdef MULTIPLICADOR_PARITY_EN
   logic par;
`endif

   logic [8:0] sb_q[$];   // {parity, product} expected one cycle later
   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   multiplicador_4x4 dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .e   (e),
      .f   (f),
      .g   (g),
      .h   (h),
      .o0  (o0),
      .o1  (o1),
      .o2  (o2),
      .o3  (o3),
      .o4  (o4),
      .o5  (o5),
      .o6  (o6),
      .o7  (o7)
`ifdef MULTIPLICADOR_PARITY_EN
      ,
      .par (par)
`endif
   );

   task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got par=%b p=%b (%0d), expected par=%b p=%b (%0d)",
                  tag, got[8], got[7:0], got[7:0], exp[8], exp[7:0], exp[7:0]);
      end
   endtask

   function automatic logic [8:0] model(input logic [3:0] x, input logic [3:0] y, input logic r);
      logic [7:0] p;
      if (r) p = 8'h00;
      else   p = 8'(x) * 8'(y);
      return {^p, p};
   endfunction

   // Apply operands, push the expectation, then pop and compare the
   // product that appears after the next rising edge.
   task automatic drive(input string tag, input logic [3:0] x, input logic [3:0] y, input logic r);
      logic [8:0] got;
      logic [8:0] exp;
      {a, b, c, d} = x;
      {e, f, g, h} = y;
      rst          = r;
      sb_q.push_back(model(x, y, r));
      @(posedge clk);
      #1;
      got[7:0] = {o0, o1, o2, o3, o4, o5, o6, o7};
      exp      = sb_q.pop_front();
`ifdef MULTIPLICADOR_PARITY_EN
      got[8] = par;
`else
      got[8] = 1'b0;
      exp[8] = 1'b0;
`endif
      check_val(tag, got, exp);
   endtask

   initial begin
      // Reset held two cycles with 15x15 present, then released.
      drive("rst_hold0", 4'd15, 4'd15, 1'b1);
      drive("rst_hold1", 4'd15, 4'd15, 1'b1);
      drive("rst_rel_15x15", 4'd15, 4'd15, 1'b0);

      // Zero and identity.
      drive("zero_0x13", 4'd0, 4'd13, 1'b0);
      drive("ident_1x13", 4'd1, 4'd13, 1'b0);
      drive("ident_9x1", 4'd9, 4'd1, 1'b0);
      drive("zero_15x0", 4'd15, 4'd0, 1'b0);

      // Mid values.
      drive("mid_5x6", 4'd5, 4'd6, 1'b0);
      drive("mid_12x11", 4'd12, 4'd11, 1'b0);
      drive("mid_7x9", 4'd7, 4'd9, 1'b0);

      // Reset asserted on the same edge as 10x10: in-flight product dropped.
      drive("midrst_10x10", 4'd10, 4'd10, 1'b1);
      drive("midrel_10x10", 4'd10, 4'd10, 1'b0);

      // Parity-oriented vectors (product checked in both builds).
      drive("par_15x15", 4'd15, 4'd15, 1'b0);
      drive("par_3x5", 4'd3, 4'd5, 1'b0);
      drive("par_2x1", 4'd2, 4'd1, 1'b0);

      // Exhaustive back-to-back sweep.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            drive($sformatf("sweep_%0dx%0d", i, j), 4'(i), 4'(j), 1'b0);
         end
      end

      // Commutativity: swapped operand order must give the model's A*B.
      for (int k = 0; k < 16; k++) begin
         logic [3:0] x;
         logic [3:0] y;
         x = 4'($urandom_range(15, 0));
         y = 4'($urandom_range(15, 0));
         drive($sformatf("comm_%0dx%0d", y, x), y, x, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
